// File: rtl/text_console_buffer_pkg.sv
// Shared constants for the text console: screen geometry, control codes,
// FSM encoding and the logical-to-physical cell address helper.
package text_console_buffer_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = 12;

    typedef logic [AW-1:0] addr_t;
    typedef logic [6:0]    char_t;

    localparam char_t      CHAR_SPACE = 7'h20;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_FF      = 8'h0C;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLR_ALL  = 2'd1;
    localparam logic [1:0] S_CLR_LINE = 2'd2;

    // Rows are stored circularly; top is the physical row shown first.
    function automatic addr_t cell_addr(
        input logic [4:0] row,
        input logic [6:0] col,
        input logic [4:0] top
    );
        logic [5:0] phys;
        phys = {1'b0, row} + {1'b0, top};
        if (phys >= 6'(ROWS))
            phys = phys - 6'(ROWS);
        return addr_t'(phys) * addr_t'(COLS) + addr_t'(col);
    endfunction

endpackage

// File: rtl/text_console_buffer_if.sv
// Byte-stream write channel into the console engine.
// Ports: wr_valid/wr_data from the producer, wr_ready back from the console.
interface text_console_buffer_if;

    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/text_console_buffer_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, 1-cycle, old data on collision).
module console_char_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12,
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_console_buffer.sv
// 80x30 text console: terminal engine (cursor, scroll, clears) plus video read port.
// Ports: clk_100MHz, reset (sync, low), wr (byte channel), x/y pixel in, char_code/cursor_on out.
module text_console_buffer
    import text_console_buffer_pkg::*;
#(
    parameter int BLINK_TICKS = 25_000_000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    text_console_buffer_if.slave  wr,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    output logic [6:0]            char_code,
    output logic                  cursor_on
);

    localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;

    logic [1:0]    state, state_d;
    logic [6:0]    cur_col, col_d;
    logic [4:0]    cur_row, row_d;
    logic [4:0]    top_row, top_d;
    addr_t         clr_addr, clr_addr_d;
    addr_t         clr_last, clr_last_d;
    logic          ready_q;
    logic          we;
    addr_t         waddr;
    char_t         wdata;
    logic          nl;

    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          vld_q;
    logic          inr_q;
    logic          in_range;
    logic [6:0]    rd_col;
    logic [4:0]    rd_row;
    addr_t         raddr;
    char_t         ram_q;

    assign wr.wr_ready = ready_q;

    always_comb begin
        state_d    = state;
        col_d      = cur_col;
        row_d      = cur_row;
        top_d      = top_row;
        clr_addr_d = clr_addr;
        clr_last_d = clr_last;
        we         = 1'b0;
        waddr      = clr_addr;
        wdata      = CHAR_SPACE;
        nl         = 1'b0;
        unique case (state)
            S_CLR_ALL, S_CLR_LINE: begin
                we = 1'b1;
                if (clr_addr == clr_last)
                    state_d = S_IDLE;
                else
                    clr_addr_d = clr_addr + addr_t'(1);
            end
            default: begin
                if (wr.wr_valid && ready_q) begin
                    unique case (1'b1)
                        (wr.wr_data >= 8'h20 && wr.wr_data <= 8'h7E): begin
                            we    = 1'b1;
                            waddr = cell_addr(cur_row, cur_col, top_row);
                            wdata = wr.wr_data[6:0];
                            if (cur_col == 7'(COLS-1)) begin
                                col_d = '0;
                                nl    = 1'b1;
                            end else begin
                                col_d = cur_col + 7'd1;
                            end
                        end
                        (wr.wr_data == CH_LF): begin
                            col_d = '0;
                            nl    = 1'b1;
                        end
                        (wr.wr_data == CH_CR): col_d = '0;
                        (wr.wr_data == CH_BS): begin
                            if (cur_col != '0) begin
                                col_d = cur_col - 7'd1;
                                we    = 1'b1;
                                waddr = cell_addr(cur_row, cur_col - 7'd1, top_row);
                            end
                        end
                        (wr.wr_data == CH_FF): begin
                            col_d      = '0;
                            row_d      = '0;
                            top_d      = '0;
                            state_d    = S_CLR_ALL;
                            clr_addr_d = '0;
                            clr_last_d = addr_t'(CELLS-1);
                        end
                        default: ;
                    endcase
                    if (nl) begin
                        if (cur_row != 5'(ROWS-1)) begin
                            row_d = cur_row + 5'd1;
                        end else begin
                            // Old top row becomes the new bottom line: blank it.
                            top_d = (top_row == 5'(ROWS-1)) ? '0 : top_row + 5'd1;
                            state_d    = S_CLR_LINE;
                            clr_addr_d = addr_t'(top_row) * addr_t'(COLS);
                            clr_last_d = clr_addr_d + addr_t'(COLS-1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state    <= S_CLR_ALL;
            cur_col  <= '0;
            cur_row  <= '0;
            top_row  <= '0;
            clr_addr <= '0;
            clr_last <= addr_t'(CELLS-1);
            ready_q  <= 1'b0;
        end else begin
            state    <= state_d;
            cur_col  <= col_d;
            cur_row  <= row_d;
            top_row  <= top_d;
            clr_addr <= clr_addr_d;
            clr_last <= clr_last_d;
            ready_q  <= (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_TICKS-1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign rd_col   = x[9:3];
    assign rd_row   = y[8:4];
    assign in_range = (x < 10'(COLS*8)) && (y < 10'(ROWS*16));
    assign raddr    = in_range ? cell_addr(rd_row, rd_col, top_row) : '0;

    console_char_ram #(
        .DEPTH (CELLS),
        .AW    (AW),
        .DW    (7)
    ) u_ram (
        .clk   (clk_100MHz),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            vld_q     <= 1'b0;
            inr_q     <= 1'b0;
            cursor_on <= 1'b0;
        end else begin
            vld_q     <= 1'b1;
            inr_q     <= in_range;
            cursor_on <= in_range && phase &&
                         (rd_col == cur_col) && (rd_row == cur_row);
        end
    end

    // RAM output has no reset; hold 0 until the first post-reset read.
    assign char_code = !vld_q ? 7'h00 : (inr_q ? ram_q : CHAR_SPACE);

endmodule

// File: tb/tb_text_console_buffer.sv
// Randomized bench for text_console_buffer against a logical-screen model.
// Drives the byte channel and pixel coordinates; checks cells, cursor, blink and busy times.
module tb_text_console_buffer;
    import text_console_buffer_pkg::*;

    localparam int BLINK = 64;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b0;
    logic [9:0] x          = '0;
    logic [9:0] y          = '0;
    logic [6:0] char_code;
    logic       cursor_on;

    text_console_buffer_if wif();

    text_console_buffer #(
        .BLINK_TICKS (BLINK)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .wr         (wif),
        .x          (x),
        .y          (y),
        .char_code  (char_code),
        .cursor_on  (cursor_on)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    always @(posedge clk_100MHz) ecount <= reset ? ecount + 1 : 0;

    logic [6:0] scr [ROWS][COLS];
    int cc, cr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_phase();
        return (ecount > 0 && ((ecount - 1) / BLINK) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 7'h20;
        cc = 0;
        cr = 0;
    endtask

    task automatic model_nl(output int busy);
        busy = 0;
        if (cr < ROWS - 1) begin
            cr++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                scr[r] = scr[r + 1];
            for (int c = 0; c < COLS; c++)
                scr[ROWS - 1][c] = 7'h20;
            busy = COLS;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output int busy);
        busy = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[cr][cc] = b[6:0];
            if (cc == COLS - 1) begin
                cc = 0;
                model_nl(busy);
            end else begin
                cc++;
            end
        end else if (b == 8'h0A) begin
            cc = 0;
            model_nl(busy);
        end else if (b == 8'h0D) begin
            cc = 0;
        end else if (b == 8'h08) begin
            if (cc > 0) begin
                cc--;
                scr[cr][cc] = 7'h20;
            end
        end else if (b == 8'h0C) begin
            model_clear();
            busy = CELLS;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wif.wr_ready && n < 3000) begin
            @(negedge clk_100MHz);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int busy, n;
        wait_ready(n);
        if (!wif.wr_ready)
            chk("ready_timeout", 32'(wif.wr_ready), 1);
        wif.wr_valid = 1'b1;
        wif.wr_data  = b;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        wif.wr_valid = 1'b0;
        model_byte(b, busy);
        wait_ready(n);
        chk($sformatf("busy_%02h", b), n, busy);
    endtask

    task automatic read_px(input int px, input int py, output logic [6:0] ch, output logic co);
        x = 10'(px);
        y = 10'(py);
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        ch = char_code;
        co = cursor_on;
    endtask

    task automatic verify_screen(input string tag);
        logic [6:0] ch;
        logic       co;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_px(c * 8 + $urandom_range(0, 7), r * 16 + $urandom_range(0, 15), ch, co);
                chk($sformatf("%s_cell_%0d_%0d", tag, c, r), ch, scr[r][c]);
                chk($sformatf("%s_cur_%0d_%0d", tag, c, r), co,
                    (r == cr && c == cc) ? exp_phase() : 0);
            end
        end
    endtask

    task automatic blink_check(input string tag);
        logic [6:0] ch;
        logic       co;
        for (int i = 0; i < 2 * BLINK + 4; i++) begin
            read_px(cc * 8 + $urandom_range(0, 7), cr * 16 + $urandom_range(0, 15), ch, co);
            chk(tag, co, exp_phase());
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        int k;
        logic [7:0] b;
        k = $urandom_range(0, 99);
        if (k < 70)      b = 8'(8'h20 + $urandom_range(0, 94));
        else if (k < 80) b = 8'h0A;
        else if (k < 85) b = 8'h0D;
        else if (k < 92) b = 8'h08;
        else if (k < 93) b = 8'h0C;
        else begin
            b = 8'($urandom_range(0, 255));
            if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D ||
                b == 8'h08 || b == 8'h0C)
                b = 8'h7F;
        end
        return b;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ch;
        logic       co;
        int         n;

        wif.wr_valid = 1'b0;
        wif.wr_data  = '0;
        model_clear();

        repeat (3) @(negedge clk_100MHz);
        chk("rst_ready", wif.wr_ready, 0);
        chk("rst_char", char_code, 0);
        chk("rst_cursor", cursor_on, 0);
        reset = 1'b1;
        wait_ready(n);
        chk("init_sweep", n, CELLS);
        verify_screen("init");
        blink_check("blink_init");

        for (int i = 0; i < 10; i++) begin
            read_px($urandom_range(640, 1023), $urandom_range(0, 1023), ch, co);
            chk("oob_x_char", ch, 7'h20);
            chk("oob_x_cur", co, 0);
            read_px($urandom_range(0, 1023), $urandom_range(480, 1023), ch, co);
            chk("oob_y_char", ch, 7'h20);
            chk("oob_y_cur", co, 0);
        end

        send_str("AB");
        read_px(8, 0, ch, co);
        chk("ab_latency", ch, 7'h42);
        read_px(0, 0, ch, co);
        chk("ab_first", ch, 7'h41);
        blink_check("blink_ab");
        verify_screen("ab");

        for (int i = 0; i < 81; i++)
            send("X");
        verify_screen("wrap");

        send(8'h0C);
        for (int i = 0; i < ROWS; i++) begin
            send("Q");
            send(8'h0A);
        end
        send("Z");
        read_px(0, 28 * 16, ch, co);
        chk("scroll_q28", ch, 7'h51);
        read_px(0, 29 * 16, ch, co);
        chk("scroll_z29", ch, 7'h5A);
        verify_screen("scroll");

        send_str("hi");
        send(8'h0C);
        verify_screen("ff");

        send("A");
        send(8'h08);
        send(8'h08);
        verify_screen("bs");

        for (int i = 0; i < 35; i++)
            send(8'h0A);
        send_str("top");
        wait_ready(n);
        wif.wr_valid = 1'b1;
        wif.wr_data  = 8'h0C;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        wif.wr_valid = 1'b0;
        repeat (1000) @(negedge clk_100MHz);
        chk("mid_sweep_busy", wif.wr_ready, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b1;
        model_clear();
        wait_ready(n);
        chk("restart_sweep", n, CELLS);
        verify_screen("restart");

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 400; i++)
                send(rand_byte());
            verify_screen($sformatf("rand%0d", p));
        end
        blink_check("blink_rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_console_buffer.md
Name: text_console_buffer

Overview:
- Character-cell text buffer and terminal engine directly upstream of the text generation circuit.
- Accepts a byte stream from the processor side (ASCII plus a few control codes) and maintains an 80x30 screen of 7-bit character codes with a cursor and hardware scrolling.
- The VGA side reads it each pixel by x/y and gets back the character code for the glyph ROM, plus a blinking-cursor flag.

Parameters:
COLS, 80, character columns (640 px / 8 px glyph width)
ROWS, 30, character rows (480 px / 16 px glyph height)
BLINK_TICKS, 25_000_000, clk_100MHz cycles per cursor blink half-period

Ports:
clk_100MHz  input  1  single system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset
wr_valid  input  1  byte offered on wr_data
wr_data  input  8  ASCII byte or control code
wr_ready  output  1  block can accept a byte this cycle
x  input  10  current pixel column from vga_controller
y  input  10  current pixel row from vga_controller
char_code  output  7  character code at cell (x[9:3], y[8:4]); 1-cycle latency
cursor_on  output  1  cell under (x,y) is the cursor cell and blink phase is on; 1-cycle latency

Behaviour:
- Storage: COLS*ROWS x 7-bit dual-port RAM.
  - Write port is owned by the engine; read port is owned by the video side.
  - Physical address = phys_row*COLS + col, with phys_row = (logical_row + top_row) mod ROWS.
- Reset (reset==0 on a clock edge): cursor_col=0, cursor_row=0, top_row=0, char_code=0, cursor_on=0, wr_ready=0, blink counter=0, blink phase=1, state=CLR_ALL.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- Handshake: a byte is consumed on any edge with wr_valid && wr_ready. wr_ready is a registered output: 1 only in IDLE.
- FSM states:
  - IDLE: process the accepted byte in the same cycle.
  - CLR_ALL: write 0x20 to every cell, one per cycle, addresses 0..COLS*ROWS-1 (2400 cycles), then go to IDLE.
  - CLR_LINE: write 0x20 to the COLS cells of one physical row (80 cycles), then go to IDLE.
- Byte decode in IDLE:
  - 0x20..0x7E: write wr_data[6:0] at the cursor, then advance. If cursor_col==COLS-1: cursor_col=0 and do a newline; else cursor_col+1.
  - 0x0A (LF): cursor_col=0, newline.
  - 0x0D (CR): cursor_col=0.
  - 0x08 (BS): if cursor_col>0, cursor_col-1 and write 0x20 at the new position; at col 0, no-op (no reverse line wrap).
  - 0x0C (FF): cursor=(0,0), top_row=0, go to CLR_ALL.
  - Every other byte (0x00-0x1F except above, 0x7F-0xFF): consumed, no effect.
- Newline:
  - If cursor_row<ROWS-1: cursor_row+1, stay in IDLE.
  - Else (scroll): cursor_row stays ROWS-1; top_row = (top_row+1) mod ROWS, wrapping 29->0; go to CLR_LINE on the old top_row's physical row, which is now the bottom logical row.
- Read path:
  - col = x[9:3], row = y[8:4]; char_code is registered 1 cycle after x/y.
  - For x>=640 or y>=480, char_code=0x20 and cursor_on=0 (RGB is blanked downstream anyway).
  - Reads are never stalled. During CLR_* they return a mix of old and cleared cells.
  - A same-cycle read/write to the same address returns the old data.
- cursor_on = (col==cursor_col && row==cursor_row && blink phase), registered.
  - Blink phase toggles every BLINK_TICKS cycles, free-running.

Decomposition:
- Shared package: COLS, ROWS, CHAR_SPACE=7'h20, control-code constants (LF, CR, BS, FF), FSM state encoding.
- One sub-module: console_char_ram, a simple dual-port RAM with 1 write port, 1 registered read port, and a depth parameter, so it infers block RAM.
- Engine FSM, cursor/scroll logic, and blink counter stay in text_console_buffer.

Test Plan:
- Reset, then hold reset high -> wr_ready=0 for exactly 2400 cycles then 1; reading every cell gives 0x20; cursor_on high only at (x,y)=(0..7, 0..15) during the blink-on phase.
- Send "AB" -> cell (0,0)=0x41, (1,0)=0x42, cursor=(2,0); with x=8,y=0, char_code=0x42 one cycle later.
- Send 81 'X' -> row 0 cols 0..79 = 0x58, cell (0,1)=0x58, cursor=(1,1).
- Send 30 LF with 'Q' before each, then 'Z' -> top_row=1; wr_ready low 80 cycles after the last LF; logical row 28 col 0 = 'Q', logical row 29 col 0 = 'Z', first 'Q' gone.
- Send 'A', BS, BS -> cell (0,0)=0x20, cursor=(0,0); the second BS is a no-op.
- Send 0x0C after text with top_row!=0 -> 2400-cycle clear, top_row=0, cursor=(0,0); assert reset at cycle 1000 of the sweep -> sweep restarts, wr_ready rises 2400 cycles after reset is released.
